axis_sram_fifo: RTL and testbench

AXIS_SRAM_FIFO -- requirements
Module: axis_sram_fifo

---
 rtl/axis_sram_fifo.sv | 139 +++++++++++++
 tb/tb_axis_sram_fifo.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sram_fifo.sv
// axis_sram_fifo: first-word-fall-through stream FIFO built from one simple
// dual-port RAM (registered read) followed by an output prefetch register.
// Words travel RAM -> RAM read register -> output register; every word in
// any of the three places counts toward occupied, so the total never
// exceeds 2^SIZE.
module axis_sram_fifo #(
  parameter int WIDTH = 65,
  parameter int SIZE  = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic [SIZE:0]    space,
  output logic [SIZE:0]    occupied
);

  localparam int            DEPTH    = 1 << SIZE;
  localparam logic [SIZE:0] CAPACITY = {1'b1, {SIZE{1'b0}}};
  localparam logic [SIZE:0] CNT_ONE  = {{SIZE{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_dout_q;

  logic [SIZE-1:0]  wr_ptr_q, wr_ptr_d;
  logic [SIZE-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SIZE:0]    occupied_q, occupied_d;
  logic [SIZE:0]    space_q, space_d;
  logic             ram_valid_q, ram_valid_d;   // RAM read register holds a word
  logic             out_valid_q, out_valid_d;   // output register holds a word
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic [SIZE:0]    pipe_cnt;
  logic             do_write, do_read, ram_nonempty, out_load, ram_rd;

  // Ready/valid come straight from registers, never from the other side's handshake.
  assign i_tready = (occupied_q < CAPACITY);
  assign o_tvalid = out_valid_q;
  assign o_tdata  = out_data_q;
  assign occupied = occupied_q;
  assign space    = space_q;

  // Handshakes and the decision to move words down the read pipeline.
  always_comb begin
    do_write     = i_tvalid && i_tready;
    do_read      = out_valid_q && o_tready;
    pipe_cnt     = (SIZE+1)'(ram_valid_q) + (SIZE+1)'(out_valid_q);
    // Words still sitting in the RAM are those not yet in either register.
    ram_nonempty = (occupied_q > pipe_cnt);
    out_load     = ram_valid_q && (!out_valid_q || o_tready);
    ram_rd       = ram_nonempty && (!ram_valid_q || out_load);
  end

  // Storage array with registered read port.
  // NOTE: the RAM has no reset so it maps onto block RAM; stale contents are
  // unreachable because the pointers and valid flags are reset instead.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= i_tdata;
    if (ram_rd)   ram_dout_q    <= mem[rd_ptr_q];
  end

  // Next-state for pointers, counters and the two pipeline stages.
  always_comb begin
    // NOTE: every output is given a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occupied_d  = occupied_q;
    space_d     = space_q;
    ram_valid_d = ram_valid_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (do_write) wr_ptr_d = wr_ptr_q + SIZE'(1);
    if (ram_rd)   rd_ptr_d = rd_ptr_q + SIZE'(1);

    case ({do_write, do_read})
      2'b10: begin
        occupied_d = occupied_q + CNT_ONE;
        space_d    = space_q - CNT_ONE;
      end
      2'b01: begin
        occupied_d = occupied_q - CNT_ONE;
        space_d    = space_q + CNT_ONE;
      end
      default: ;  // idle or simultaneous read+write: counts unchanged
    endcase

    // A consumed output word is replaced by the read register in the same edge.
    if (do_read)  out_valid_d = 1'b0;
    if (out_load) begin
      out_valid_d = 1'b1;
      out_data_d  = ram_dout_q;
    end

    if (out_load) ram_valid_d = 1'b0;
    if (ram_rd)   ram_valid_d = 1'b1;

    // Synchronous flush: same state as reset, this edge's handshakes dropped.
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occupied_d  = '0;
      space_d     = CAPACITY;
      ram_valid_d = 1'b0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occupied_q  <= '0;
      space_q     <= CAPACITY;
      ram_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occupied_q  <= occupied_d;
      space_q     <= space_d;
      ram_valid_q <= ram_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_axis_sram_fifo.sv
// tb_axis_sram_fifo: randomized and directed stimulus against a queue-based
// reference model. The model holds every accepted word with the edge number
// at which it was written; the head is visible two edges after its write.
module tb_axis_sram_fifo;

  localparam int WIDTH = 65;
  localparam int SIZE  = 10;
  localparam int CAP   = 1 << SIZE;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tvalid;
  logic             o_tready = 1'b0;
  logic [SIZE:0]    space;
  logic [SIZE:0]    occupied;

  axis_sram_fifo #(.WIDTH(WIDTH), .SIZE(SIZE)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .i_tready (i_tready),
    .o_tdata  (o_tdata),
    .o_tvalid (o_tvalid),
    .o_tready (o_tready),
    .space    (space),
    .occupied (occupied)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               wcyc;
  } entry_t;

  entry_t           q[$];
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  bit               last_wr;

  // Per-test statistics.
  int               in_words, out_words, out_last, first_wr_cyc, first_valid_cyc;
  bit               last_out_tlast;
  logic [WIDTH-1:0] first_out;
  logic [31:0]      crc_in, crc_out;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [WIDTH-1:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      bit fb;
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ 32'h04C1_1DB7;
    end
    return c;
  endfunction

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].wcyc <= cyc - 2);
  endfunction

  task automatic clear_stats();
    in_words        = 0;
    out_words       = 0;
    out_last        = 0;
    first_wr_cyc    = -1;
    first_valid_cyc = -1;
    last_out_tlast  = 1'b0;
    first_out       = '0;
    crc_in          = '1;
    crc_out         = '1;
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    bit mv;
    mv = model_valid();
    check("i_tready", i_tready, q.size() < CAP);
    check("occupied", occupied, q.size());
    check("space", space, CAP - q.size());
    check("o_tvalid", o_tvalid, mv);
    if (mv) check("o_tdata", o_tdata, q[0].data);
    if (o_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
  endtask

  // One clock edge: predict the handshakes from the model, advance, compare.
  task automatic tick();
    bit wr, rd;
    wr = i_tvalid && (q.size() < CAP) && !clear;
    rd = o_tready && model_valid() && !clear;
    if (rd) begin
      if (out_words == 0) first_out = o_tdata;
      out_words++;
      crc_out        = crc_step(crc_out, o_tdata);
      last_out_tlast = o_tdata[WIDTH-1];
      if (o_tdata[WIDTH-1]) out_last++;
    end
    @(posedge clk);
    cyc++;
    last_wr = wr;
    if (clear) begin
      q.delete();
    end else begin
      if (rd) void'(q.pop_front());
      if (wr) begin
        q.push_back('{data: i_tdata, wcyc: cyc});
        in_words++;
        crc_in = crc_step(crc_in, i_tdata);
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
      end
    end
    #1;
    compare();
  endtask

  task automatic idle(input int n, input bit rdy);
    i_tvalid = 1'b0;
    o_tready = rdy;
    repeat (n) tick();
  endtask

  // Push an n-word packet (tlast on the final word); ramp or random payload.
  task automatic push_pkt(input int n, input bit ramp, input bit rdy);
    int i, guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 4 * n + 16) begin
      i_tvalid = 1'b1;
      i_tdata  = {(i == n - 1), ramp ? 64'(i) : {$urandom(), $urandom()}};
      o_tready = rdy;
      tick();
      if (last_wr) i++;
      guard++;
    end
    if (i < n) check("push_timeout", i, n);
    i_tvalid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    i_tvalid = 1'b0;
    o_tready = 1'b1;
    while (q.size() > 0 && guard < 4 * CAP + 16) begin
      tick();
      guard++;
    end
    tick();
    tick();
    check("drain_left", q.size(), 0);
  endtask

  // Asynchronous reset pulse launched between clock edges.
  task automatic reset_pulse();
    #3;
    reset = 1'b1;
    #1;
    q.delete();
    check("rst_o_tvalid", o_tvalid, 0);
    check("rst_occupied", occupied, 0);
    check("rst_space", space, CAP);
    i_tvalid = 1'b0;
    o_tready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    #2;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_stats();
    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check("por_o_tvalid", o_tvalid, 0);
    check("por_occupied", occupied, 0);
    check("por_space", space, CAP);
    #2;
    reset = 1'b0;
    tick();
    check("por_i_tready", i_tready, 1);

    // 16-word packet held back, then released.
    clear_stats();
    push_pkt(16, 1'b1, 1'b0);
    idle(3, 1'b0);
    check("p16_occupied", occupied, 16);
    drain();
    check("p16_words", out_words, 16);
    check("p16_tlast_cnt", out_last, 1);
    check("p16_tlast_pos", last_out_tlast, 1);
    check("p16_crc", crc_out, crc_in);

    // 1024-word ramp held back: fills the FIFO exactly; extra writes are ignored.
    clear_stats();
    push_pkt(1024, 1'b1, 1'b0);
    idle(2, 1'b0);
    check("ramp_space", space, 0);
    check("ramp_i_tready", i_tready, 0);
    i_tvalid = 1'b1;
    i_tdata  = {1'b0, 64'hDEAD_BEEF};
    o_tready = 1'b0;
    repeat (3) tick();
    drain();
    check("ramp_words", out_words, 1024);
    check("ramp_tlast_cnt", out_last, 1);
    check("ramp_tlast_pos", last_out_tlast, 1);
    check("ramp_crc", crc_out, crc_in);

    // Streaming 20-word packet: first o_tvalid two edges after the first write.
    clear_stats();
    push_pkt(20, 1'b0, 1'b1);
    drain();
    check("p20_latency", first_valid_cyc - first_wr_cyc, 2);
    check("p20_words", out_words, 20);
    check("p20_crc", crc_out, crc_in);

    // Ten packets separated by 30 idle clocks.
    for (int p = 0; p < 10; p++) begin
      clear_stats();
      push_pkt(20, 1'b0, 1'b1);
      idle(30, 1'b1);
      check("pkt10_words", out_words, 20);
      check("pkt10_tlast", out_last, 1);
      check("pkt10_crc", crc_out, crc_in);
    end

    // Full, then simultaneous read/write, then drain across the pointer wrap.
    clear_stats();
    push_pkt(CAP, 1'b0, 1'b0);
    check("full_occupied", occupied, CAP);
    for (int i = 0; i < 12; i++) begin
      i_tvalid = 1'b1;
      i_tdata  = {1'b0, $urandom(), $urandom()};
      o_tready = 1'b1;
      tick();
    end
    drain();
    check("full_words", out_words, in_words);
    check("full_crc", crc_out, crc_in);

    // Simultaneous read/write with a single word stored.
    clear_stats();
    push_pkt(1, 1'b0, 1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      i_tvalid = 1'b1;
      i_tdata  = {1'b0, 32'h0, 32'(i)};
      o_tready = 1'b1;
      tick();
    end
    drain();
    check("one_words", out_words, in_words);

    // Randomized traffic in phases biased toward filling and draining.
    clear_stats();
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 500; i++) begin
        i_tvalid = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 8 : 3));
        i_tdata  = {1'($urandom()), $urandom(), $urandom()};
        o_tready = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 8));
        tick();
      end
    end
    // Reset in the middle of that traffic discards everything.
    reset_pulse();
    idle(4, 1'b1);
    check("rnd_rst_valid", o_tvalid, 0);

    // Reset with 5 words stored; next written word comes out first.
    push_pkt(5, 1'b0, 1'b0);
    idle(2, 1'b0);
    reset_pulse();
    clear_stats();
    i_tvalid = 1'b1;
    i_tdata  = {1'b1, 64'h1234_5678_9ABC_DEF0};
    o_tready = 1'b1;
    tick();
    drain();
    check("rst_first_out", first_out, {1'b1, 64'h1234_5678_9ABC_DEF0});
    check("rst_out_words", out_words, 1);

    // Clear with 5 words stored, with a write and read offered on the clear edge.
    push_pkt(5, 1'b0, 1'b0);
    idle(2, 1'b0);
    clear    = 1'b1;
    i_tvalid = 1'b1;
    i_tdata  = {1'b0, 64'hBAD0_BAD0};
    o_tready = 1'b1;
    tick();
    clear    = 1'b0;
    i_tvalid = 1'b0;
    check("clr_occupied", occupied, 0);
    check("clr_space", space, CAP);
    check("clr_o_tvalid", o_tvalid, 0);
    idle(3, 1'b1);
    clear_stats();
    i_tvalid = 1'b1;
    i_tdata  = {1'b0, 64'h0F0F_0F0F_0F0F_0F0F};
    tick();
    drain();
    check("clr_first_out", first_out, {1'b0, 64'h0F0F_0F0F_0F0F_0F0F});
    check("clr_out_words", out_words, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
